// File: rtl/imem_loader.sv
// Frame-based instruction-memory loader: SYNC, 16-bit word count, LE words, XOR checksum.
// Holds the core in reset until a frame with a valid checksum has been fully written.
module imem_loader #(
  parameter int          ADDR_W      = 10,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic              clk_signal,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int          TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W-1:0] len_m1_q, len_m1_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              in_ready_q;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              acc;
  logic [15:0]       len_n;
  logic [TW-1:0]     tmo_inc;

  assign acc     = in_valid & in_ready_q;
  assign len_n   = {in_data, len_lo_q};
  assign tmo_inc = tmo_q + TW'(1);

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_m1_d   = len_m1_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    tmo_d      = '0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (acc && in_data == SYNC_BYTE) begin
          state_d = S_LEN0;
          csum_d  = '0;
        end
      end
      S_LEN0: begin
        if (acc) begin
          len_lo_d = in_data;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (acc) begin
          if (len_n == 16'd0 || {1'b0, len_n} > MAX_N) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_DATA;
            byte_idx_d = '0;
            word_idx_d = '0;
            len_m1_d   = ADDR_W'(len_n - 16'd1);
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          // Bytes arrive LSB first, so shift in from the top.
          asm_d      = {in_data, asm_q[23:8]};
          csum_d     = csum_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            wdata_d    = {in_data, asm_q};
            addr_d     = word_idx_q;
            word_idx_d = word_idx_q + ADDR_W'(1);
            if (word_idx_q == len_m1_q) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (acc) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    // Idle-cycle watchdog, only armed while a frame is in flight.
    if (!acc && (state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM})) begin
      tmo_d = tmo_inc;
      if (tmo_inc == TW'(TIMEOUT_CYC)) begin
        state_d = S_ERR;
        tmo_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_signal or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_lo_q   <= '0;
      len_m1_q   <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_m1_q   <= len_m1_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      in_ready_q <= 1'b1;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, bad lengths, gaps, timeout, mid-frame reset.
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wa [8];
  logic [31:0] wd [8];
  int          nw = 0;

  logic [7:0] dat [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

  imem_loader #(
    .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(16)
  ) dut (
    .clk_signal(clk), .reset(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1 && nw < 8) begin
      wa[nw] = 32'(imem_addr);
      wd[nw] = imem_wdata;
      nw++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Call from just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_body(input logic [7:0] cs, input int gap);
    send(8'h02);
    send(8'h00);
    for (int i = 0; i < 8; i++) begin
      send(dat[i]);
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
    end
    send(cs);
  endtask

  task automatic chk_writes(input string tag);
    chk({tag, "_nw"}, 32'(nw), 32'd2);
    chk({tag, "_a0"}, wa[0], 32'd0);
    chk({tag, "_d0"}, wd[0], 32'h0010_0513);
    chk({tag, "_a1"}, wa[1], 32'd1);
    chk({tag, "_d1"}, wd[1], 32'h0020_0593);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin wa[i] = 'x; wd[i] = 'x; end
    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we",    32'(imem_we), 32'd0);
    chk("rst_addr",  32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_hold",  32'(cpu_hold), 32'd1);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // Good frame: checksum 13^05^10^00^93^05^20^00 = B0
    send(8'hA5);
    send_body(8'hB0, 0);
    chk("good_done", 32'(done), 32'd1);
    chk("good_hold", 32'(cpu_hold), 32'd0);
    chk("good_err",  32'(error), 32'd0);
    chk_writes("good");

    // Re-sync from DONE, then a bad checksum
    nw = 0;
    send(8'hA5);
    chk("resync_done", 32'(done), 32'd0);
    chk("resync_hold", 32'(cpu_hold), 32'd1);
    chk("resync_err",  32'(error), 32'd0);
    send_body(8'h8B, 0);
    chk_writes("badcs");
    chk("badcs_err",  32'(error), 32'd1);
    chk("badcs_hold", 32'(cpu_hold), 32'd1);
    chk("badcs_done", 32'(done), 32'd0);

    // Length zero and length 1025 (> 1024 words)
    nw = 0;
    send(8'hA5); send(8'h00); send(8'h00);
    chk("len0_err", 32'(error), 32'd1);
    send(8'hA5); send(8'h01);
    chk("len_mid_err", 32'(error), 32'd0);
    send(8'h04);
    chk("lenbig_err", 32'(error), 32'd1);
    chk("len_nowrite", 32'(nw), 32'd0);

    // Garbage ignored, then a frame with 3-cycle gaps
    send(8'h00); send(8'hFF); send(8'h12);
    chk("garbage_err", 32'(error), 32'd1);
    send(8'hA5);
    send_body(8'hB0, 3);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_hold", 32'(cpu_hold), 32'd0);
    chk_writes("gap");

    // Timeout after 16 idle cycles mid-frame
    nw = 0;
    send(8'hA5); send(8'h01); send(8'h00); send(8'h11);
    repeat (15) @(posedge clk);
    #1;
    chk("tmo15_err",  32'(error), 32'd0);
    chk("tmo15_hold", 32'(cpu_hold), 32'd1);
    @(posedge clk);
    #1;
    chk("tmo16_err", 32'(error), 32'd1);
    chk("tmo_nowrite", 32'(nw), 32'd0);
    send(8'hA5);
    send_body(8'hB0, 0);
    chk("post_tmo_done", 32'(done), 32'd1);
    chk_writes("post_tmo");

    // Reset right after the first word is written
    nw = 0;
    send(8'hA5); send(8'h02); send(8'h00);
    for (int i = 0; i < 4; i++) send(dat[i]);
    chk("mid_we", 32'(imem_we), 32'd1);
    #6;
    rst_n = 1'b0;
    #1;
    chk("mid_ready", 32'(in_ready), 32'd0);
    chk("mid_we0",   32'(imem_we), 32'd0);
    chk("mid_addr",  32'(imem_addr), 32'd0);
    chk("mid_wdata", imem_wdata, 32'd0);
    chk("mid_hold",  32'(cpu_hold), 32'd1);
    chk("mid_done",  32'(done), 32'd0);
    chk("mid_err",   32'(error), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_nw", 32'(nw), 32'd1);
    chk("mid_d0", wd[0], 32'h0010_0513);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    nw = 0;
    send(8'hA5);
    send_body(8'hB0, 0);
    chk("reload_done", 32'(done), 32'd1);
    chk("reload_hold", 32'(cpu_hold), 32'd0);
    chk_writes("reload");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
